config_frame_loader: RTL and testbench

Next-generation coefficient configuration loader for the configurable FIR filter. It pops bytes from the read side of the config async FIFO and parses framed write bursts: sync byte, start address, word count, payload and XOR checksum. Words are assembled from COEF_BYTES bytes, MSB first, and held in an internal shadow buffer. They are committed to the filter register file only after the checksum passes, so a corrupted frame never reaches the coefficient registers.

---
 rtl/config_frame_loader_if.sv | 27 ++
 rtl/config_frame_loader.sv | 250 +++++++++++++++++++++++++
 tb/tb_config_frame_loader.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_frame_loader_if.sv
// FIFO read side plus register-file write side seen by the coefficient frame loader.
// The loader drives the master modport; the FIFO/register-file environment uses slave.
interface config_frame_loader_if #(
  parameter int ADDR_W = 3,
  parameter int WORD_W = 8
);
  logic              Empty;
  logic [7:0]        Data;
  logic              RINC;
  logic              WrEn;
  logic [ADDR_W-1:0] RegAddr;
  logic [WORD_W-1:0] RegData;
  logic              Busy;
  logic              FrameDone;
  logic              FrameErr;
  logic [1:0]        ErrCode;

  modport master (
    input  Empty, Data,
    output RINC, WrEn, RegAddr, RegData, Busy, FrameDone, FrameErr, ErrCode
  );

  modport slave (
    output Empty, Data,
    input  RINC, WrEn, RegAddr, RegData, Busy, FrameDone, FrameErr, ErrCode
  );
endinterface

// File: rtl/config_frame_loader.sv
// Parses sync/addr/len/payload/xor-checksum frames from a FWFT FIFO into a shadow
// buffer and writes the words to the coefficient registers only once the checksum passes.
module config_frame_loader #(
  parameter int         NUM_REGS   = 8,
  parameter int         ADDR_W     = 3,
  parameter int         COEF_BYTES = 1,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TIMEOUT    = 255
) (
  input  logic CLK,
  input  logic RSTn,
  config_frame_loader_if.master bus
);

  localparam int               WORD_W    = 8 * COEF_BYTES;
  localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int               TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM   = TMO_W'(TIMEOUT);
  localparam logic [1:0]       LAST_BYTE = 2'(COEF_BYTES - 1);
  localparam logic [8:0]       NREGS9    = 9'(NUM_REGS);

  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_CSUM  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        commit_idx_q, commit_idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [WORD_W-1:0] reg_data_q;
  logic              frame_done_q, frame_done_d;
  logic              frame_err_q, frame_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;

  logic              pop;
  logic              parsing;
  logic              timeout_hit;
  logic [TMO_W-1:0]  tmo_inc;
  logic [8:0]        end_addr;
  logic [WORD_W-1:0] word_full;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_widx;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;

  logic [WORD_W-1:0] buf_mem [NUM_REGS];

  assign parsing   = (state_q == S_ADDR) || (state_q == S_LEN) ||
                     (state_q == S_DATA) || (state_q == S_CSUM);
  assign pop       = !bus.Empty && (state_q != S_COMMIT);
  assign tmo_inc   = tmo_q + 1'b1;
  assign end_addr  = 9'(start_q) + {1'b0, bus.Data};
  // Bytes arrive MSB first, so each new byte enters at the bottom of the word.
  assign word_full = (shift_q << 8) | WORD_W'(bus.Data);
  assign buf_widx  = IDX_W'(word_idx_q);

  assign timeout_hit = (TIMEOUT != 0) && parsing && !pop && (tmo_inc == TMO_LIM);

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    len_d        = len_q;
    csum_d       = csum_q;
    word_idx_d   = word_idx_q;
    byte_idx_d   = byte_idx_q;
    commit_idx_d = commit_idx_q;
    shift_d      = shift_q;
    tmo_d        = (parsing && !pop) ? tmo_inc : '0;
    wr_en_d      = 1'b0;
    reg_addr_d   = reg_addr_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_code_d   = err_code_q;
    buf_we       = 1'b0;
    rd_en        = 1'b0;
    rd_idx       = '0;

    case (state_q)
      S_HUNT: begin
        if (pop && (bus.Data == SYNC_BYTE)) begin
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (pop) begin
          start_d = bus.Data[ADDR_W-1:0];
          csum_d  = bus.Data;
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (pop) begin
          len_d      = bus.Data;
          csum_d     = csum_q ^ bus.Data;
          word_idx_d = '0;
          byte_idx_d = '0;
          shift_d    = '0;
          if ((bus.Data == 8'd0) || (end_addr > NREGS9)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_RANGE;
            state_d     = S_HUNT;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (pop) begin
          csum_d  = csum_q ^ bus.Data;
          shift_d = word_full;
          if (byte_idx_q == LAST_BYTE) begin
            buf_we     = 1'b1;
            byte_idx_d = '0;
            word_idx_d = word_idx_q + 8'd1;
            if (word_idx_q == len_q - 8'd1) begin
              state_d = S_CSUM;
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      S_CSUM: begin
        if (pop) begin
          if (bus.Data == csum_q) begin
            // First write leaves on the same edge that accepts the checksum.
            state_d      = S_COMMIT;
            wr_en_d      = 1'b1;
            reg_addr_d   = start_q;
            rd_en        = 1'b1;
            rd_idx       = '0;
            commit_idx_d = 8'd1;
            frame_done_d = (len_q == 8'd1);
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = S_HUNT;
          end
        end
      end

      S_COMMIT: begin
        if (commit_idx_q < len_q) begin
          wr_en_d      = 1'b1;
          reg_addr_d   = start_q + ADDR_W'(commit_idx_q);
          rd_en        = 1'b1;
          rd_idx       = IDX_W'(commit_idx_q);
          commit_idx_d = commit_idx_q + 8'd1;
          frame_done_d = (commit_idx_q == len_q - 8'd1);
        end else begin
          state_d = S_HUNT;
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase

    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = S_HUNT;
    end

    busy_d = (state_d != S_HUNT);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q      <= S_HUNT;
      start_q      <= '0;
      len_q        <= '0;
      csum_q       <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      commit_idx_q <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      reg_addr_q   <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      word_idx_q   <= word_idx_d;
      byte_idx_q   <= byte_idx_d;
      commit_idx_q <= commit_idx_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      wr_en_q      <= wr_en_d;
      reg_addr_q   <= reg_addr_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  // Shadow buffer: contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge CLK) begin
    if (buf_we) begin
      buf_mem[buf_widx] <= word_full;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      reg_data_q <= '0;
    end else if (rd_en) begin
      reg_data_q <= buf_mem[rd_idx];
    end
  end

  assign bus.RINC      = pop;
  assign bus.WrEn      = wr_en_q;
  assign bus.RegAddr   = reg_addr_q;
  assign bus.RegData   = reg_data_q;
  assign bus.Busy      = busy_q;
  assign bus.FrameDone = frame_done_q;
  assign bus.FrameErr  = frame_err_q;
  assign bus.ErrCode   = err_code_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Drives two loader instances (1-byte and 2-byte words) from FIFO models and scores
// register writes and frame errors against expectations queued with the stimulus.
module tb_config_frame_loader;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  config_frame_loader_if #(.ADDR_W(3), .WORD_W(8))  b1 ();
  config_frame_loader_if #(.ADDR_W(3), .WORD_W(16)) b2 ();

  config_frame_loader #(
    .NUM_REGS(8), .ADDR_W(3), .COEF_BYTES(1), .SYNC_BYTE(8'hA5), .TIMEOUT(16)
  ) dut1 (.CLK(clk), .RSTn(rstn), .bus(b1));

  config_frame_loader #(
    .NUM_REGS(8), .ADDR_W(3), .COEF_BYTES(2), .SYNC_BYTE(8'hA5), .TIMEOUT(255)
  ) dut2 (.CLK(clk), .RSTn(rstn), .bus(b2));

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    logic        done;
  } wexp_t;

  typedef struct packed {
    logic        dut;
    logic        gap;
    logic [3:0]  nb;
    logic [95:0] b;
    logic [2:0]  nw;
    logic [95:0] w;
    logic [1:0]  err;
  } vec_t;

  logic [7:0] fq1[$];
  logic [7:0] fq2[$];
  wexp_t      ew1[$];
  wexp_t      ew2[$];
  logic [1:0] ee1[$];
  logic [1:0] ee2[$];

  int  n_vec = 0;
  int  n_bad = 0;
  int  stepno = 0;
  bit  gap = 1'b0;
  bit  phase = 1'b0;
  int  first_wr [2];
  int  last_wr  [2];
  int  wr_cnt   [2];
  int  err_cnt  [2];
  int  err_step [2];
  int  last_pop [2];

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int id, input logic we, input logic [7:0] a,
                         input logic [15:0] d, input logic done,
                         input logic ferr, input logic [1:0] code);
    wexp_t      e;
    logic [1:0] ec;
    bit         have;
    if (we) begin
      n_vec++;
      have = (id == 0) ? (ew1.size() != 0) : (ew2.size() != 0);
      if (!have) begin
        n_bad++;
        $display("FAIL unexpected_write dut%0d: got addr %0h data %0h, expected no write", id + 1, a, d);
      end else begin
        e = (id == 0) ? ew1.pop_front() : ew2.pop_front();
        if (a !== e.a || d !== e.d || done !== e.done) begin
          n_bad++;
          $display("FAIL write dut%0d: got addr %0h data %0h done %0b, expected addr %0h data %0h done %0b",
                   id + 1, a, d, done, e.a, e.d, e.done);
        end
      end
      if (wr_cnt[id] == 0) first_wr[id] = stepno;
      last_wr[id] = stepno;
      wr_cnt[id]++;
    end else if (done) begin
      n_vec++;
      n_bad++;
      $display("FAIL framedone_without_write dut%0d: got 1 expected 0", id + 1);
    end
    if (ferr) begin
      n_vec++;
      err_step[id] = stepno;
      err_cnt[id]++;
      have = (id == 0) ? (ee1.size() != 0) : (ee2.size() != 0);
      if (!have) begin
        n_bad++;
        $display("FAIL unexpected_frameerr dut%0d: got code %0b, expected no error", id + 1, code);
      end else begin
        ec = (id == 0) ? ee1.pop_front() : ee2.pop_front();
        if (code !== ec) begin
          n_bad++;
          $display("FAIL errcode dut%0d: got %0b expected %0b", id + 1, code, ec);
        end
      end
    end
  endtask

  // One clock: present FIFO state, sample RINC before the edge, pop, sample outputs after.
  task automatic step();
    logic r1, r2;
    @(negedge clk);
    phase = ~phase;
    b1.Empty = (fq1.size() == 0) || (gap && phase);
    b1.Data  = (fq1.size() != 0) ? fq1[0] : 8'h00;
    b2.Empty = (fq2.size() == 0) || (gap && phase);
    b2.Data  = (fq2.size() != 0) ? fq2[0] : 8'h00;
    #1;
    r1 = b1.RINC;
    r2 = b2.RINC;
    if (b1.Empty) chk("rinc_while_empty_dut1", 32'(r1), 32'd0);
    if (b2.Empty) chk("rinc_while_empty_dut2", 32'(r2), 32'd0);
    @(posedge clk);
    stepno++;
    if (r1 && fq1.size() != 0) begin
      void'(fq1.pop_front());
      if (fq1.size() == 0) last_pop[0] = stepno;
    end
    if (r2 && fq2.size() != 0) begin
      void'(fq2.pop_front());
      if (fq2.size() == 0) last_pop[1] = stepno;
    end
    #1;
    observe(0, b1.WrEn, 8'(b1.RegAddr), 16'(b1.RegData), b1.FrameDone, b1.FrameErr, b1.ErrCode);
    observe(1, b2.WrEn, 8'(b2.RegAddr), b2.RegData, b2.FrameDone, b2.FrameErr, b2.ErrCode);
  endtask

  function automatic bit pending();
    return (fq1.size() != 0) || (fq2.size() != 0) || (ew1.size() != 0) ||
           (ew2.size() != 0) || (ee1.size() != 0) || (ee2.size() != 0);
  endfunction

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (pending() && guard < 300) begin
      step();
      guard++;
    end
    repeat (4) step();
    chk({name, "_leftover_expectations"},
        32'(ew1.size() + ew2.size() + ee1.size() + ee2.size() + fq1.size() + fq2.size()), 32'd0);
    fq1.delete(); fq2.delete(); ew1.delete(); ew2.delete(); ee1.delete(); ee2.delete();
  endtask

  task automatic clear_track();
    for (int k = 0; k < 2; k++) begin
      wr_cnt[k] = 0; err_cnt[k] = 0; first_wr[k] = -1; last_wr[k] = -1;
      err_step[k] = -1; last_pop[k] = -1;
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_wren"},      32'(b1.WrEn),      32'd0);
    chk({name, "_busy"},      32'(b1.Busy),      32'd0);
    chk({name, "_framedone"}, 32'(b1.FrameDone), 32'd0);
    chk({name, "_frameerr"},  32'(b1.FrameErr),  32'd0);
    chk({name, "_errcode"},   32'(b1.ErrCode),   32'd0);
    chk({name, "_regaddr"},   32'(b1.RegAddr),   32'd0);
    chk({name, "_regdata"},   32'(b1.RegData),   32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       v;
    wexp_t      e;
    logic [23:0] ent;
    int         nb, nw, id;

    vt[0]  = '{dut:1'b0, gap:1'b0, nb:4'd7, b:96'hA5_02_03_11_22_33_01, nw:3'd3,
               w:96'h02_0011_03_0022_04_0033, err:2'b00};
    vt[1]  = '{dut:1'b0, gap:1'b0, nb:4'd7, b:96'hA5_02_03_11_22_33_00, nw:3'd0, w:96'h0, err:2'b10};
    vt[2]  = '{dut:1'b0, gap:1'b0, nb:4'd5, b:96'hA5_00_01_7E_7F, nw:3'd1, w:96'h00_007E, err:2'b00};
    vt[3]  = '{dut:1'b0, gap:1'b0, nb:4'd7, b:96'hA5_06_03_11_22_33_00, nw:3'd0, w:96'h0, err:2'b01};
    vt[4]  = '{dut:1'b0, gap:1'b0, nb:4'd3, b:96'hA5_00_00, nw:3'd0, w:96'h0, err:2'b01};
    vt[5]  = '{dut:1'b0, gap:1'b1, nb:4'd7, b:96'hA5_02_03_11_22_33_01, nw:3'd3,
               w:96'h02_0011_03_0022_04_0033, err:2'b00};
    vt[6]  = '{dut:1'b0, gap:1'b0, nb:4'd7, b:96'h00_FF_A5_07_01_5A_5C, nw:3'd1, w:96'h07_005A, err:2'b00};
    vt[7]  = '{dut:1'b0, gap:1'b0, nb:4'd3, b:96'hA5_07_02, nw:3'd0, w:96'h0, err:2'b01};
    vt[8]  = '{dut:1'b1, gap:1'b0, nb:4'd8, b:96'h00_FF_A5_00_01_12_34_27, nw:3'd1, w:96'h00_1234, err:2'b00};
    vt[9]  = '{dut:1'b1, gap:1'b1, nb:4'd8, b:96'hA5_03_02_AB_CD_00_01_66, nw:3'd2,
               w:96'h03_ABCD_04_0001, err:2'b00};
    vt[10] = '{dut:1'b0, gap:1'b0, nb:4'd7, b:96'hA5_05_03_A5_A5_A5_A3, nw:3'd3,
               w:96'h05_00A5_06_00A5_07_00A5, err:2'b00};
    vt[11] = '{dut:1'b0, gap:1'b0, nb:4'd6, b:96'hA5_01_02_10_20_34, nw:3'd0, w:96'h0, err:2'b10};

    b1.Empty = 1'b1; b1.Data = 8'h00;
    b2.Empty = 1'b1; b2.Data = 8'h00;
    clear_track();
    rstn = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    chk("reset_dut2_busy", 32'(b2.Busy), 32'd0);
    chk("reset_dut2_regdata", 32'(b2.RegData), 32'd0);
    rstn = 1'b1;
    $display("reset released");

    for (int i = 0; i < 12; i++) begin
      v  = vt[i];
      nb = int'(v.nb);
      nw = int'(v.nw);
      id = int'(v.dut);
      gap = v.gap;
      clear_track();
      for (int j = 0; j < nb; j++) begin
        if (id == 0) fq1.push_back(v.b[(nb - 1 - j) * 8 +: 8]);
        else         fq2.push_back(v.b[(nb - 1 - j) * 8 +: 8]);
      end
      for (int j = 0; j < nw; j++) begin
        ent    = v.w[(nw - 1 - j) * 24 +: 24];
        e.a    = ent[23:16];
        e.d    = ent[15:0];
        e.done = (j == nw - 1);
        if (id == 0) ew1.push_back(e); else ew2.push_back(e);
      end
      if (v.err != 2'b00) begin
        if (id == 0) ee1.push_back(v.err); else ee2.push_back(v.err);
      end
      drain($sformatf("vec%0d", i));
      if (nw > 0) begin
        chk($sformatf("vec%0d_first_write_after_csum", i), 32'(first_wr[id]), 32'(last_pop[id]));
        chk($sformatf("vec%0d_writes_consecutive", i), 32'(last_wr[id] - first_wr[id]), 32'(nw - 1));
        ent = v.w[23:0];
        chk($sformatf("vec%0d_regaddr_hold", i),
            (id == 0) ? 32'(b1.RegAddr) : 32'(b2.RegAddr), 32'(ent[23:16]));
      end
      chk($sformatf("vec%0d_busy_idle", i), (id == 0) ? 32'(b1.Busy) : 32'(b2.Busy), 32'd0);
      $display("vec %0d dut%0d gap=%0b: %0d bytes, %0d writes, %0d frame errors",
               i, id + 1, v.gap, nb, wr_cnt[id], err_cnt[id]);
    end
    gap = 1'b0;

    // Range error is flagged right after the LEN byte pops.
    clear_track();
    fq1.push_back(8'hA5); fq1.push_back(8'h06); fq1.push_back(8'h03);
    ee1.push_back(2'b01);
    drain("range_timing");
    chk("range_err_cycle", 32'(err_step[0]), 32'(last_pop[0]));
    $display("range timing: LEN popped at step %0d, FrameErr at step %0d", last_pop[0], err_step[0]);

    // Starvation after ADDR: error exactly 16 cycles after the last pop.
    clear_track();
    fq1.push_back(8'hA5); fq1.push_back(8'h01);
    ee1.push_back(2'b11);
    drain("timeout");
    chk("timeout_cycles", 32'(err_step[0] - last_pop[0]), 32'd16);
    chk("timeout_busy_low", 32'(b1.Busy), 32'd0);
    $display("timeout: last pop step %0d, FrameErr step %0d", last_pop[0], err_step[0]);

    // Reset in the middle of DATA aborts the frame with no writes.
    clear_track();
    fq1.push_back(8'hA5); fq1.push_back(8'h02); fq1.push_back(8'h03); fq1.push_back(8'h11);
    begin
      int guard;
      guard = 0;
      while (fq1.size() != 0 && guard < 50) begin
        step();
        guard++;
      end
    end
    chk("pre_reset_busy", 32'(b1.Busy), 32'd1);
    rstn = 1'b0;
    step();
    chk_reset_outputs("midframe_reset");
    rstn = 1'b1;
    fq1.push_back(8'h22); fq1.push_back(8'h33); fq1.push_back(8'h01);
    fq1.push_back(8'hA5); fq1.push_back(8'h00); fq1.push_back(8'h01);
    fq1.push_back(8'h7E); fq1.push_back(8'h7F);
    e.a = 8'h00; e.d = 16'h007E; e.done = 1'b1;
    ew1.push_back(e);
    drain("post_reset");
    chk("post_reset_write_count", 32'(wr_cnt[0]), 32'd1);
    $display("mid-frame reset: %0d writes after recovery", wr_cnt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
